// File: rtl/md_sequencer_pkg.sv
// Shared opcode encodings and helper definitions for the multiply/divide sequencer.
// The controller decode that drives op/start imports these same constants.
package md_sequencer_pkg;

  localparam int MD_OP_W = 3;

  localparam logic [MD_OP_W-1:0] MD_MULT  = 3'd0;
  localparam logic [MD_OP_W-1:0] MD_MULTU = 3'd1;
  localparam logic [MD_OP_W-1:0] MD_DIV   = 3'd2;
  localparam logic [MD_OP_W-1:0] MD_DIVU  = 3'd3;
  localparam logic [MD_OP_W-1:0] MD_MTHI  = 3'd4;
  localparam logic [MD_OP_W-1:0] MD_MTLO  = 3'd5;

  typedef enum logic {
    MD_IDLE = 1'b0,
    MD_RUN  = 1'b1
  } md_state_e;

  // The first four opcodes are the ones that occupy the unit for several cycles.
  function automatic logic md_is_multicycle(input logic [MD_OP_W-1:0] op);
    return (op <= MD_DIVU);
  endfunction

endpackage

// File: rtl/md_latency_cnt.sv
// Loadable down-counter that tracks the remaining latency of the in-flight MD op.
// It saturates at zero and flags that condition for the sequencer's IDLE state.
module md_latency_cnt #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load_i,
  input  logic [WIDTH-1:0] load_val_i,
  output logic [WIDTH-1:0] cnt_o,
  output logic             zero_o
);

  logic [WIDTH-1:0] cnt_q;
  logic [WIDTH-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - WIDTH'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o  = cnt_q;
  assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/md_sequencer.sv
// Multiply/divide sequencer: owns HI/LO, models the multi-cycle MDU latency and
// requests a pipeline stall while a D-stage MD instruction would see stale state.
module md_sequencer
  import md_sequencer_pkg::*;
#(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [MD_OP_W-1:0] op,
  input  logic [31:0]        a,
  input  logic [31:0]        b,
  input  logic               d_md_use,
  output logic               busy,
  output logic               stall_req,
  output logic [31:0]        hi,
  output logic [31:0]        lo
);

  localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CNT_W      = $clog2(MAX_CYCLES + 1);

  logic [31:0] hi_q, hi_d;
  logic [31:0] lo_q, lo_d;
  logic [31:0] pend_hi_q, pend_hi_d;
  logic [31:0] pend_lo_q, pend_lo_d;
  logic        pend_vld_q, pend_vld_d;

  logic             cnt_load;
  logic [CNT_W-1:0] cnt_load_val;
  logic [CNT_W-1:0] cnt;
  logic             cnt_zero;
  md_state_e        state;

  logic [63:0] prod_s;
  logic [63:0] prod_u;
  logic [31:0] b_safe;
  logic [31:0] quo_s, rem_s, quo_u, rem_u;

  md_latency_cnt #(
    .WIDTH(CNT_W)
  ) u_cnt (
    .clk       (clk),
    .reset     (reset),
    .load_i    (cnt_load),
    .load_val_i(cnt_load_val),
    .cnt_o     (cnt),
    .zero_o    (cnt_zero)
  );

  assign state = cnt_zero ? MD_IDLE : MD_RUN;

  // A zero divisor is swapped for 1 so the dividers never produce X; its result is discarded.
  assign b_safe = (b == '0) ? 32'd1 : b;
  assign prod_s = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
  assign prod_u = {32'd0, a} * {32'd0, b};
  assign quo_s  = $signed(a) / $signed(b_safe);
  assign rem_s  = $signed(a) % $signed(b_safe);
  assign quo_u  = a / b_safe;
  assign rem_u  = a % b_safe;

  always_comb begin
    hi_d         = hi_q;
    lo_d         = lo_q;
    pend_hi_d    = pend_hi_q;
    pend_lo_d    = pend_lo_q;
    pend_vld_d   = pend_vld_q;
    cnt_load     = 1'b0;
    cnt_load_val = '0;
    case (state)
      MD_IDLE: begin
        if (start) begin
          case (op)
            MD_MULT: begin
              {pend_hi_d, pend_lo_d} = prod_s;
              pend_vld_d   = 1'b1;
              cnt_load     = 1'b1;
              cnt_load_val = CNT_W'(MULT_CYCLES);
            end
            MD_MULTU: begin
              {pend_hi_d, pend_lo_d} = prod_u;
              pend_vld_d   = 1'b1;
              cnt_load     = 1'b1;
              cnt_load_val = CNT_W'(MULT_CYCLES);
            end
            MD_DIV: begin
              if (b != '0) begin
                pend_hi_d = rem_s;
                pend_lo_d = quo_s;
              end
              pend_vld_d   = (b != '0);
              cnt_load     = 1'b1;
              cnt_load_val = CNT_W'(DIV_CYCLES);
            end
            MD_DIVU: begin
              if (b != '0) begin
                pend_hi_d = rem_u;
                pend_lo_d = quo_u;
              end
              pend_vld_d   = (b != '0);
              cnt_load     = 1'b1;
              cnt_load_val = CNT_W'(DIV_CYCLES);
            end
            MD_MTHI: hi_d = a;
            MD_MTLO: lo_d = a;
            default: ;
          endcase
        end
      end
      MD_RUN: begin
        // Commit on the edge where the counter leaves 1; a divide-by-zero leaves HI/LO alone.
        if (cnt == CNT_W'(1)) begin
          if (pend_vld_q) begin
            hi_d = pend_hi_q;
            lo_d = pend_lo_q;
          end
          pend_vld_d = 1'b0;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      hi_q       <= '0;
      lo_q       <= '0;
      pend_hi_q  <= '0;
      pend_lo_q  <= '0;
      pend_vld_q <= 1'b0;
    end else begin
      hi_q       <= hi_d;
      lo_q       <= lo_d;
      pend_hi_q  <= pend_hi_d;
      pend_lo_q  <= pend_lo_d;
      pend_vld_q <= pend_vld_d;
    end
  end

  assign busy      = !cnt_zero;
  assign stall_req = d_md_use & (busy | (start & md_is_multicycle(op)));
  assign hi        = hi_q;
  assign lo        = lo_q;

endmodule

// File: tb/tb_md_sequencer.sv
// Self-checking bench for md_sequencer: a table of MD ops checked through a scoreboard
// queue, plus hand-written sequences for moves, divide-by-zero, stalls and reset mid-run.
module tb_md_sequencer;
  import md_sequencer_pkg::*;

  logic               clk = 1'b0;
  logic               reset;
  logic               start;
  logic [MD_OP_W-1:0] op;
  logic [31:0]        a;
  logic [31:0]        b;
  logic               d_md_use;
  logic               busy;
  logic               stall_req;
  logic [31:0]        hi;
  logic [31:0]        lo;

  int checks = 0;
  int errors = 0;

  typedef struct {
    string              name;
    logic [MD_OP_W-1:0] op;
    logic [31:0]        a;
    logic [31:0]        b;
    logic [31:0]        hi;
    logic [31:0]        lo;
    int                 cyc;
  } vec_t;

  typedef struct {
    string       name;
    logic [31:0] hi;
    logic [31:0] lo;
  } exp_t;

  exp_t sbq[$];
  vec_t vecs[9];

  always #5 clk = ~clk;

  md_sequencer #(
    .MULT_CYCLES(5),
    .DIV_CYCLES (10)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .op       (op),
    .a        (a),
    .b        (b),
    .d_md_use (d_md_use),
    .busy     (busy),
    .stall_req(stall_req),
    .hi       (hi),
    .lo       (lo)
  );

  // The hazard unit must never let a new MD op reach E while one is in flight.
  always @(posedge clk) begin
    if (reset) begin
      assert (!(start && busy)) else $error("[TB] start asserted while busy");
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input logic [MD_OP_W-1:0] o, input logic [31:0] av,
                               input logic [31:0] bv, input logic du);
    @(negedge clk);
    start    = 1'b1;
    op       = o;
    a        = av;
    b        = bv;
    d_md_use = du;
    #1;
  endtask

  task automatic runOp(input vec_t v, input logic du);
    logic [31:0] hiHold;
    logic [31:0] loHold;
    int          n;
    exp_t        e;
    sbq.push_back('{v.name, v.hi, v.lo});
    hiHold = hi;
    loHold = lo;
    applyStimulus(v.op, v.a, v.b, du);
    checkOutput({v.name, " stall at issue"}, {31'd0, stall_req}, {31'd0, du});
    @(negedge clk);
    start = 1'b0;
    a     = '0;
    b     = '0;
    #1;
    n = 0;
    while (busy && n < 50) begin
      checkOutput({v.name, " hi held"}, hi, hiHold);
      checkOutput({v.name, " lo held"}, lo, loHold);
      checkOutput({v.name, " stall busy"}, {31'd0, stall_req}, {31'd0, du});
      n++;
      @(negedge clk);
      #1;
    end
    checkOutput({v.name, " busy cycles"}, 32'(n), 32'(v.cyc));
    checkOutput({v.name, " stall after"}, {31'd0, stall_req}, 32'd0);
    d_md_use = 1'b0;
    if (sbq.size() == 0) begin
      checks++;
      errors++;
      $display("[TB] FAIL %s: scoreboard empty, got nothing, expected an entry", v.name);
    end else begin
      e = sbq.pop_front();
      checkOutput({e.name, " hi"}, hi, e.hi);
      checkOutput({e.name, " lo"}, lo, e.lo);
    end
  endtask

  task automatic doMove(input logic [MD_OP_W-1:0] o, input logic [31:0] av,
                        input logic [31:0] expHi, input logic [31:0] expLo, input string name);
    applyStimulus(o, av, 32'd0, 1'b1);
    checkOutput({name, " stall"}, {31'd0, stall_req}, 32'd0);
    @(negedge clk);
    start    = 1'b0;
    d_md_use = 1'b0;
    #1;
    checkOutput({name, " busy"}, {31'd0, busy}, 32'd0);
    checkOutput({name, " hi"}, hi, expHi);
    checkOutput({name, " lo"}, lo, expLo);
  endtask

  initial begin
    vec_t vz;
    reset    = 1'b0;
    start    = 1'b0;
    op       = '0;
    a        = '0;
    b        = '0;
    d_md_use = 1'b1;
    #2;
    checkOutput("reset busy", {31'd0, busy}, 32'd0);
    checkOutput("reset stall", {31'd0, stall_req}, 32'd0);
    checkOutput("reset hi", hi, 32'd0);
    checkOutput("reset lo", lo, 32'd0);
    @(negedge clk);
    reset    = 1'b1;
    d_md_use = 1'b0;

    vecs[0] = '{"multu max",  MD_MULTU, 32'hFFFFFFFF, 32'd2,        32'h00000001, 32'hFFFFFFFE, 5};
    vecs[1] = '{"mult neg",   MD_MULT,  32'hFFFFFFFD, 32'd4,        32'hFFFFFFFF, 32'hFFFFFFF4, 5};
    vecs[2] = '{"div -7/2",   MD_DIV,   32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD, 10};
    vecs[3] = '{"divu 100/7", MD_DIVU,  32'd100,      32'd7,        32'd2,        32'd14,       10};
    vecs[4] = '{"mult 2^32",  MD_MULT,  32'h00010000, 32'h00010000, 32'h00000001, 32'h00000000, 5};
    vecs[5] = '{"div 7/-2",   MD_DIV,   32'd7,        32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, 10};
    vecs[6] = '{"multu 2^62", MD_MULTU, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, 5};
    vecs[7] = '{"mult min*2", MD_MULT,  32'h80000000, 32'd2,        32'hFFFFFFFF, 32'h00000000, 5};
    vecs[8] = '{"divu big",   MD_DIVU,  32'hFFFFFFFF, 32'h00000010, 32'h0000000F, 32'h0FFFFFFF, 10};

    foreach (vecs[i]) begin
      runOp(vecs[i], 1'b0);
    end

    doMove(MD_MTHI, 32'hDEADBEEF, 32'hDEADBEEF, 32'h0FFFFFFF, "mthi");
    doMove(MD_MTLO, 32'h00001234, 32'hDEADBEEF, 32'h00001234, "mtlo");
    doMove(MD_MTHI, 32'h00000011, 32'h00000011, 32'h00001234, "mthi 11");
    doMove(MD_MTLO, 32'h00000022, 32'h00000011, 32'h00000022, "mtlo 22");

    vz = '{"div by zero", MD_DIV, 32'd5, 32'd0, 32'h00000011, 32'h00000022, 10};
    runOp(vz, 1'b0);

    vz = '{"mult stalled", MD_MULT, 32'd6, 32'd7, 32'd0, 32'd42, 5};
    runOp(vz, 1'b1);

    // Undefined opcode must leave everything alone.
    applyStimulus(3'd6, 32'hFFFF, 32'd1, 1'b1);
    checkOutput("undef stall", {31'd0, stall_req}, 32'd0);
    @(negedge clk);
    start    = 1'b0;
    d_md_use = 1'b0;
    #1;
    checkOutput("undef busy", {31'd0, busy}, 32'd0);
    checkOutput("undef hi", hi, 32'd0);
    checkOutput("undef lo", lo, 32'd42);

    // Reset pulled during the fourth busy cycle of a divu.
    applyStimulus(MD_DIVU, 32'd100, 32'd7, 1'b0);
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    checkOutput("pre-reset busy", {31'd0, busy}, 32'd1);
    reset    = 1'b0;
    d_md_use = 1'b1;
    #1;
    checkOutput("midrun busy", {31'd0, busy}, 32'd0);
    checkOutput("midrun stall", {31'd0, stall_req}, 32'd0);
    checkOutput("midrun hi", hi, 32'd0);
    checkOutput("midrun lo", lo, 32'd0);
    @(negedge clk);
    reset    = 1'b1;
    d_md_use = 1'b0;
    repeat (12) begin
      @(negedge clk);
      #1;
      checkOutput("post-reset busy", {31'd0, busy}, 32'd0);
      checkOutput("post-reset hi", hi, 32'd0);
      checkOutput("post-reset lo", lo, 32'd0);
    end

    checkOutput("scoreboard drained", 32'(sbq.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
